mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 64, meaning memory-side data width; instruction word width is fixed at 32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ireq_valid  input  1 and ireq_addr  input  ADDR_W: the fetch request.
REQ-006 SHALL have ports iresp_ok  output  1 and iresp_data  output  32: the fetch response.
REQ-007 SHALL have port group dreq_valid  input  1; dreq_write  input  1; dreq_addr  input  ADDR_W; dreq_size  input  3; dreq_strobe  input  DATA_W/8; dreq_wdata  input  DATA_W: the data request.
REQ-008 SHALL have ports dresp_ok  output  1 and dresp_data  output  DATA_W: the data response.
REQ-009 SHALL have port group mreq_valid  output  1; mreq_write  output  1; mreq_addr  output  ADDR_W; mreq_size  output  3; mreq_strobe  output  DATA_W/8; mreq_wdata  output  DATA_W: the shared memory request.
REQ-010 SHALL have ports mresp_ready  input  1 and mresp_data  input  DATA_W: memory completion strobe and read data.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
- Encoding is free.
REQ-012 In IDLE, arbitration SHALL run as follows:
- Only dreq_valid set: go BUSY_D.
- Only ireq_valid set: go BUSY_I.
- Both set: grant the requester opposite to the last_grant register, then update last_grant.
- Neither set: stay IDLE.
REQ-013 On grant, the FSM SHALL latch the granted request fields into internal registers.
- Instruction grant: mreq_write=0, mreq_size=3'b010, mreq_strobe=0, mreq_wdata=0.
REQ-014 In BUSY_I/BUSY_D, the outputs SHALL behave as follows:
- mreq_valid=1.
- mreq_* driven only from the latched registers.
- Requester inputs changing or deasserting SHALL NOT alter mreq_* or abort the transaction.
REQ-015 In BUSY_x with mresp_ready=1, the FSM SHALL capture mresp_data and go RESP; with mresp_ready=0 it stays in BUSY_x indefinitely.
REQ-016 In RESP, response outputs SHALL be driven for exactly one cycle, then the FSM returns to IDLE unconditionally.
- mreq_valid=0.
- The granted side's *_ok=1; the other side's *_ok=0.
REQ-017 iresp_data SHALL be the captured data word selected by the latched address:
- Latched ireq_addr[2]=1: captured[63:32].
- Latched ireq_addr[2]=0: captured[31:0].
REQ-018 dresp_data SHALL equal the full captured mresp_data for both reads and writes.
REQ-019 iresp_ok and dresp_ok SHALL never be high in the same cycle.
- Outside RESP, both SHALL be 0 and both *_resp_data SHALL hold their last value.
REQ-020 Latency from a valid request seen in IDLE:
- Cycle N: grant.
- Cycle N+1: mreq_valid=1.
- Ready seen at cycle M: *_ok=1 at M+1.
- Minimum request-to-ok: 2 cycles, zero-wait memory.
REQ-021 Back-to-back requests SHALL pay at least one IDLE cycle between RESP and the next mreq_valid; a requester holding valid after its ok SHALL be treated as a new request.
REQ-022 mreq_valid SHALL never be 1 in IDLE or RESP.
REQ-023 mresp_ready outside BUSY_x SHALL be ignored.

Reset
REQ-024 While reset=1, regardless of clk, the block SHALL hold:
- State IDLE; last_grant=I, so the first contention grants D.
- mreq_valid=0, iresp_ok=0, dresp_ok=0.
- All latched/captured registers and data outputs 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse.
- The memory side is required to tolerate a dropped mreq_valid.

Verification
REQ-026 Single fetch: ireq_valid=1, addr=0x8000_0004, mresp_ready after 3 wait cycles with data 0xAABBCCDD_11223344 -> mreq_valid for 4 cycles; iresp_ok one cycle; iresp_data=0xAABBCCDD.
REQ-027 Contention after reset: ireq_valid=dreq_valid=1 held, zero-wait memory -> grant order D,I,D,I; ok pulses alternate; no cycle with both ok high.
REQ-028 Data write: dreq_write=1, addr=0x100, strobe=0x0F, wdata=0x1234 -> mreq_write=1, mreq_strobe=0x0F, mreq_wdata=0x1234 held stable until ready; dresp_ok one pulse.
REQ-029 Request withdrawn: dreq_valid drops one cycle after grant -> mreq_* unchanged, transaction completes, dresp_ok still pulses once.
REQ-030 Reset mid-op: reset asserted while in BUSY_I, not aligned to a clock edge -> mreq_valid=0 immediately; no iresp_ok; after release, a fresh fetch completes normally.
REQ-031 Spurious ready: mresp_ready=1 in IDLE with no requests -> no state change; both ok signals stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: shares one memory port between instruction fetch and data
// accesses, alternating grants under contention and returning a single-cycle response pulse.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_ok,
    output logic [31:0]         iresp_data,
    input  logic                dreq_valid,
    input  logic                dreq_write,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    output logic                dresp_ok,
    output logic [DATA_W-1:0]   dresp_data,
    output logic                mreq_valid,
    output logic                mreq_write,
    output logic [ADDR_W-1:0]   mreq_addr,
    output logic [2:0]          mreq_size,
    output logic [DATA_W/8-1:0] mreq_strobe,
    output logic [DATA_W-1:0]   mreq_wdata,
    input  logic                mresp_ready,
    input  logic [DATA_W-1:0]   mresp_data
);

    // state  | meaning
    // IDLE   | arbitrating, no memory request outstanding
    // BUSY_I | fetch request on memory port, waiting for mresp_ready
    // BUSY_D | data request on memory port, waiting for mresp_ready
    // RESP   | one-cycle response pulse to the granted requester
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last_grant_d;
    logic                  r_grant_d;
    logic                  r_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [2:0]            r_size;
    logic [DATA_W/8-1:0]   r_strobe;
    logic [DATA_W-1:0]     r_wdata;
    logic [31:0]           r_iresp_data;
    logic [DATA_W-1:0]     r_dresp_data;
    logic                  w_grant;
    logic                  w_grant_d;
    logic                  w_capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_grant   = (r_state == IDLE) && (ireq_valid || dreq_valid);
        // Under contention the side that did not win last time goes first.
        w_grant_d = dreq_valid && (!ireq_valid || !r_last_grant_d);
        w_capture = ((r_state == BUSY_I) || (r_state == BUSY_D)) && mresp_ready;
        w_next    = r_state;
        case (r_state)
            IDLE:           if (w_grant) w_next = w_grant_d ? BUSY_D : BUSY_I;
            BUSY_I, BUSY_D: if (mresp_ready) w_next = RESP;
            RESP:           w_next = IDLE;
            default:        w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant_d <= 1'b0;
            r_grant_d      <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_size         <= '0;
            r_strobe       <= '0;
            r_wdata        <= '0;
            r_iresp_data   <= '0;
            r_dresp_data   <= '0;
        end else begin
            if (w_grant) begin
                r_grant_d      <= w_grant_d;
                r_last_grant_d <= w_grant_d;
                r_write        <= w_grant_d ? dreq_write  : 1'b0;
                r_addr         <= w_grant_d ? dreq_addr   : ireq_addr;
                r_size         <= w_grant_d ? dreq_size   : 3'b010;
                r_strobe       <= w_grant_d ? dreq_strobe : '0;
                r_wdata        <= w_grant_d ? dreq_wdata  : '0;
            end
            // Only the granted side's data register moves; the other keeps its last value.
            if (w_capture) begin
                if (r_grant_d) r_dresp_data <= mresp_data;
                else           r_iresp_data <= r_addr[2] ? mresp_data[32 +: 32] : mresp_data[0 +: 32];
            end
        end
    end

    assign mreq_valid  = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign mreq_write  = r_write;
    assign mreq_addr   = r_addr;
    assign mreq_size   = r_size;
    assign mreq_strobe = r_strobe;
    assign mreq_wdata  = r_wdata;
    assign iresp_ok    = (r_state == RESP) && !r_grant_d;
    assign dresp_ok    = (r_state == RESP) && r_grant_d;
    assign iresp_data  = r_iresp_data;
    assign dresp_data  = r_dresp_data;

endmodule
